// File: rtl/prbs31_burst_ctrl_if.sv
// prbs31_burst_ctrl_if
//   Groups the control pins and the PRBS output stream of prbs31_burst_ctrl.
//   Signals:
//     seed_byte/seed_wr   seed load port; bytes are written LSB byte first
//     start/burst_len     start a burst of burst_len bytes
//     abort               terminate the active burst
//     out_byte/out_valid/out_ready   valid/ready PRBS byte stream
//     busy/done/err/remaining        status
//   Modports:
//     master  drives control and out_ready, observes status and stream
//     slave   the controller side
interface prbs31_burst_ctrl_if #(
  parameter int unsigned LEN_W = 16
);
  logic [7:0]       seed_byte;
  logic             seed_wr;
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             abort;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] remaining;

  modport master (
    output seed_byte, seed_wr, start, burst_len, abort, out_ready,
    input  out_byte, out_valid, busy, done, err, remaining
  );

  modport slave (
    input  seed_byte, seed_wr, start, burst_len, abort, out_ready,
    output out_byte, out_valid, busy, done, err, remaining
  );
endinterface

// File: rtl/prbs31_burst_ctrl.sv
// prbs31_burst_ctrl
//   Burst sequencer around a PRBS31 (x^31 + x^28 + 1) byte generator. A 31-bit
//   seed is shifted in over a byte port; each start reloads the generator from
//   the seed and emits burst_len bytes on a valid/ready stream. Abort ends the
//   burst early; done pulses for one cycle at the end of every burst.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous reset, active-high (1 = reset asserted)
//     bus    prbs31_burst_ctrl_if slave modport (control, stream, status)
module prbs31_burst_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prbs31_burst_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      seed_q, seed_d;
  logic [30:0]      lfsr_q, lfsr_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic [7:0]       step_byte;
  logic [30:0]      step_next;
  logic             xfer;

  // Eight serial LFSR steps; the first generated bit lands in bit 7.
  function automatic logic [38:0] prbs_step(input logic [30:0] s);
    logic [30:0] t;
    logic [7:0]  by;
    logic        b;
    t  = s;
    by = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b  = t[30] ^ t[27];
      t  = {t[29:0], b};
      by = {by[6:0], b};
    end
    return {by, t};
  endfunction

  assign {step_byte, step_next} = prbs_step(lfsr_q);
  assign xfer = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      seed_q      <= 32'h7FFF_FFFF;
      lfsr_q      <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      rem_q       <= rem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    rem_d       = rem_q;

    // Seed writes are only accepted while idle; anywhere else they are flagged.
    if (bus.seed_wr) begin
      if (state_q == S_IDLE) begin
        seed_d = {bus.seed_byte, seed_q[31:8]};
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (seed_q[30:0] == '0) begin
            err_d = 1'b1;
          end else if (bus.burst_len == '0) begin
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            lfsr_d  = seed_q[30:0];
            rem_d   = bus.burst_len;
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        out_byte_d  = step_byte;
        lfsr_d      = step_next;
        out_valid_d = 1'b1;
        state_d     = S_RUN;
      end

      S_RUN: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        // A transfer coinciding with abort still counts, but nothing new is issued.
        if (xfer) begin
          rem_d = rem_q - LEN_W'(1);
        end
        if (bus.abort) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end else if (xfer) begin
          if (rem_q == LEN_W'(1)) begin
            out_valid_d = 1'b0;
            state_d     = S_DONE;
          end else begin
            out_byte_d = step_byte;
            lfsr_d     = step_next;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out_byte  = out_byte_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.remaining = rem_q;

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
module tb_prbs31_burst_ctrl;

  logic clk;
  logic rst;

  prbs31_burst_ctrl_if #(.LEN_W(16)) bus ();

  prbs31_burst_ctrl #(.LEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  int          xfer_cnt;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_b[0:255];
  logic [7:0]  ref_b[0:7];
  logic [31:0] model_seed;

  logic        prev_v, prev_r, prev_a;
  logic [7:0]  prev_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference generator written as the bit recurrence a[n] = a[n-31] ^ a[n-28],
  // where a[0..30] is the seed read from bit 30 down to bit 0.
  task automatic push_expected(input logic [30:0] s, input int nbytes);
    bit         a[0:2047];
    logic [7:0] by;
    int         idx;
    for (int k = 0; k < 31; k++) a[k] = s[30-k];
    for (int i = 0; i < nbytes; i++) begin
      by = '0;
      for (int j = 0; j < 8; j++) begin
        idx    = 31 + 8*i + j;
        a[idx] = a[idx-31] ^ a[idx-28];
        by     = {by[6:0], a[idx]};
      end
      exp_q.push_back(by);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_a = 1'b0;
      prev_b = '0;
    end else begin
      if (prev_v && !prev_r && !prev_a) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_byte", bus.out_byte, prev_b);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          check("byte", bus.out_byte, exp_q.pop_front());
        end
        got_b[xfer_cnt & 255] = bus.out_byte;
        xfer_cnt++;
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_a = bus.abort;
      prev_b = bus.out_byte;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_seed = 32'h7FFF_FFFF;
    exp_q.delete();
    tick();
  endtask

  task automatic load_seed(input logic [31:0] val);
    for (int i = 0; i < 4; i++) begin
      bus.seed_byte = val[8*i +: 8];
      bus.seed_wr   = 1'b1;
      tick();
    end
    bus.seed_wr = 1'b0;
    model_seed  = val;
  endtask

  task automatic run_burst(input int len, input bit toggle, input bit inject);
    bit seen;
    push_expected(model_seed[30:0], len);
    xfer_cnt      = 0;
    bus.out_ready = 1'b1;
    bus.burst_len = 16'(len);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("lat_busy", bus.busy, 1);
    check("lat_valid0", bus.out_valid, 0);
    tick();
    check("lat_valid1", bus.out_valid, 1);
    seen = 1'b0;
    for (int c = 0; c < 4*len + 20 && !seen; c++) begin
      if (xfer_cnt == len) begin
        check("done_timing", bus.done, 1);
        seen = 1'b1;
      end else begin
        if (toggle) bus.out_ready = ~bus.out_ready;
        if (inject && c == 2) begin
          bus.start     = 1'b1;
          bus.seed_wr   = 1'b1;
          bus.seed_byte = 8'hA5;
        end else begin
          bus.start   = 1'b0;
          bus.seed_wr = 1'b0;
        end
        tick();
      end
    end
    bus.start   = 1'b0;
    bus.seed_wr = 1'b0;
    if (!seen) check("timeout", xfer_cnt, len);
    check("xfer_count", xfer_cnt, len);
    check("rem_final", bus.remaining, 0);
    check("busy_at_done", bus.busy, 0);
    tick();
    check("done_pulse_end", bus.done, 0);
    check("rem_hold", bus.remaining, 0);
    check("q_empty", exp_q.size(), 0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    xfer_cnt      = 0;
    model_seed    = 32'h7FFF_FFFF;
    rst           = 1'b1;
    bus.seed_byte = '0;
    bus.seed_wr   = 1'b0;
    bus.start     = 1'b0;
    bus.burst_len = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state, before any clock edge.
    #3;
    check("rst_valid", bus.out_valid, 0);
    check("rst_byte", bus.out_byte, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rem", bus.remaining, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Default seed burst.
    run_burst(4, 1'b0, 1'b0);
    check("def_b0", got_b[0], 8'h00);
    check("def_b1", got_b[1], 8'h00);
    check("def_b2", got_b[2], 8'h00);
    check("def_b3", got_b[3], 8'h0E);

    // Zero-length burst goes straight to done.
    bus.burst_len = '0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zl_done", bus.done, 1);
    check("zl_busy", bus.busy, 0);
    check("zl_valid", bus.out_valid, 0);
    check("zl_rem", bus.remaining, 0);
    tick();
    check("zl_done_end", bus.done, 0);

    // Seed of one: leading zero bytes, then a long burst.
    load_seed(32'h0000_0001);
    run_burst(3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) check("seed1_zero", got_b[i], 8'h00);
    run_burst(64, 1'b0, 1'b0);

    // Backpressure must not change the sequence.
    load_seed(32'h1234_5678);
    run_burst(8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ref_b[i] = got_b[i];
    run_burst(8, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) check("bp_same_seq", got_b[i], ref_b[i]);
    check("err_clean", bus.err, 0);

    // Abort after three transfers of a ten byte burst.
    load_seed(32'h0BAD_F00D);
    push_expected(model_seed[30:0], 3);
    xfer_cnt      = 0;
    bus.out_ready = 1'b1;
    bus.burst_len = 16'd10;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 40 && xfer_cnt < 3; c++) tick();
    check("abort_pre_cnt", xfer_cnt, 3);
    bus.out_ready = 1'b0;
    bus.abort     = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_done", bus.done, 1);
    check("abort_rem", bus.remaining, 7);
    check("abort_busy", bus.busy, 0);
    tick();
    check("abort_done_end", bus.done, 0);
    check("abort_rem_hold", bus.remaining, 7);
    check("abort_q_empty", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    check("abort_err", bus.err, 0);

    // Zero seed is rejected.
    load_seed(32'h0000_0000);
    bus.burst_len = 16'd4;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zs_err", bus.err, 1);
    check("zs_busy", bus.busy, 0);
    tick();
    check("zs_busy2", bus.busy, 0);
    check("zs_valid", bus.out_valid, 0);
    do_reset();
    check("reset_clears_err", bus.err, 0);

    // start/seed_wr while running flag err and leave the burst alone.
    load_seed(32'hDEAD_BEEF);
    run_burst(6, 1'b0, 1'b1);
    check("busy_err", bus.err, 1);
    run_burst(6, 1'b0, 1'b0);
    check("err_sticky", bus.err, 1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    push_expected(model_seed[30:0], 20);
    xfer_cnt      = 0;
    bus.burst_len = 16'd20;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_rem", bus.remaining, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    model_seed = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_done", bus.done, 0);
    end
    check("arst_err", bus.err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
